// File: rtl/scale_by_pow2.sv
// Multiplies a beat by 2^shift. Overflow either saturates or wraps, and overflowed deliveries are counted.
// Two-stage valid/ready pipeline: 2-cycle latency, 1 beat/cycle, and a stalled output holds its data stable.
module scale_by_pow2 #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3,
  parameter bit SIGNED  = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf,
  input  logic               ovf_clr,
  output logic [CNT_W-1:0]   ovf_count
);

  // One guard bit beyond WIDTH+max_shift keeps the sign of the exact product.
  localparam int PW = WIDTH + (1 << SHIFT_W);

  logic               r_s1_vld;
  logic [WIDTH-1:0]   r_s1_data;
  logic [SHIFT_W-1:0] r_s1_shift;
  logic               r_s1_sat;
  logic               r_s2_vld;
  logic [WIDTH-1:0]   r_s2_data;
  logic               r_s2_ovf;
  logic [CNT_W-1:0]   r_ovf_count;

  logic               w_s2_load;
  logic               w_s1_move;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_neg;
  logic [PW-1:0]      w_ext;
  logic [PW-1:0]      w_prod;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_sat_val;
  logic [WIDTH-1:0]   w_res;

  assign w_s2_load  = !r_s2_vld || out_ready;
  assign w_s1_move  = r_s1_vld && w_s2_load;
  assign in_ready   = !rst && (!r_s1_vld || w_s2_load);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_vld && out_ready;

  assign w_neg  = SIGNED ? r_s1_data[WIDTH-1] : 1'b0;
  assign w_ext  = {{(PW-WIDTH){w_neg}}, r_s1_data};
  assign w_prod = w_ext << r_s1_shift;

  always_comb begin
    w_ovf     = 1'b0;
    w_sat_val = {WIDTH{1'b1}};
    if (SIGNED) begin
      // In range only if every bit from WIDTH-1 upward matches the operand sign.
      w_ovf     = (w_prod[PW-1:WIDTH-1] != {(PW-WIDTH+1){w_neg}});
      w_sat_val = w_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_ovf     = |w_prod[PW-1:WIDTH];
    end
    w_res = (w_ovf && r_s1_sat) ? w_sat_val : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shift <= '0;
      r_s1_sat   <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_vld   <= 1'b1;
      r_s1_data  <= in_data;
      r_s1_shift <= in_shift;
      r_s1_sat   <= in_sat;
    end else if (w_s1_move) begin
      r_s1_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_ovf  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_res;
        r_s2_ovf  <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      r_ovf_count <= '0;
    end else if (w_out_fire && r_s2_ovf && (r_ovf_count != {CNT_W{1'b1}})) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign out_valid = r_s2_vld;
  assign out_data  = r_s2_data;
  assign out_ovf   = r_s2_ovf;
  assign ovf_count = r_ovf_count;

endmodule
